// File: rtl/clk_en_gen.sv
// clk_en_gen: runtime-programmable fractional clock-enable generator.
// Define CLK_EN_GEN_TOGGLE_EN to add per-channel clk_tgl outputs.
module clk_en_gen #(
  parameter int NUM_CH      = 5,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 64,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LK_W = (LOCK_CYCLES > 0) ?
                        $clog2(LOCK_CYCLES + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_run,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_mul,
  input  logic [ACC_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
`ifdef CLK_EN_GEN_TOGGLE_EN
  output logic [NUM_CH-1:0] clk_tgl,
`endif
  output logic              locked
);

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  mul_q [NUM_CH];
  logic [ACC_W-1:0]  mul_d [NUM_CH];
  logic [ACC_W-1:0]  div_q [NUM_CH];
  logic [ACC_W-1:0]  div_d [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [NUM_CH-1:0] wr_hit;
  logic              err_q, err_d;
  logic [LK_W-1:0]   lock_q, lock_d;
  logic              locked_q, locked_d;
  logic              accept;
`ifdef CLK_EN_GEN_TOGGLE_EN
  logic [NUM_CH-1:0] tgl_q, tgl_d;
`endif

  always_comb begin
    accept = cfg_we
           && (int'(cfg_ch) < NUM_CH)
           && (cfg_div != '0)
           && (cfg_mul <= cfg_div);
    err_d  = cfg_we && !accept;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = accept && (int'(cfg_ch) == i);
      sum[i]    = {1'b0, acc_q[i]} + {1'b0, mul_q[i]};
      mul_d[i]  = wr_hit[i] ? cfg_mul : mul_q[i];
      div_d[i]  = wr_hit[i] ? cfg_div : div_q[i];
      acc_d[i]  = acc_q[i];
      ce_d[i]   = 1'b0;
      // Clear wins over run; a new ratio starts from zero phase.
      if (sync || wr_hit[i]) begin
        acc_d[i] = '0;
      end else if (ch_run[i]) begin
        if (sum[i] >= {1'b0, div_q[i]}) begin
          ce_d[i]  = 1'b1;
          acc_d[i] = ACC_W'(sum[i] - {1'b0, div_q[i]});
        end else begin
          acc_d[i] = sum[i][ACC_W-1:0];
        end
      end
    end
    if (accept || sync) begin
      lock_d = LK_W'(LOCK_CYCLES);
    end else if (lock_q != '0) begin
      lock_d = lock_q - LK_W'(1);
    end else begin
      lock_d = lock_q;
    end
    locked_d = (lock_q == '0);
  end

`ifdef CLK_EN_GEN_TOGGLE_EN
  always_comb begin
    tgl_d = tgl_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync || wr_hit[i]) tgl_d[i] = 1'b0;
      else tgl_d[i] = tgl_q[i] ^ ce_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tgl_q <= '0;
    else tgl_q <= tgl_d;
  end

  assign clk_tgl = tgl_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        mul_q[i] <= ACC_W'(1);
        div_q[i] <= ACC_W'(1);
      end
      ce_q     <= '0;
      err_q    <= 1'b0;
      lock_q   <= LK_W'(LOCK_CYCLES);
      locked_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        mul_q[i] <= mul_d[i];
        div_q[i] <= div_d[i];
      end
      ce_q     <= ce_d;
      err_q    <= err_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
    end
  end

  assign ce      = ce_q;
  assign cfg_err = err_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: randomized and directed checks of clk_en_gen
// against a pulse-count reference model.
module tb_clk_en_gen;

  localparam int NUM_CH      = 5;
  localparam int ACC_W       = 16;
  localparam int LOCK_CYCLES = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_run = '0;
  logic              sync = 1'b0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_ch = '0;
  logic [ACC_W-1:0]  cfg_mul = '0;
  logic [ACC_W-1:0]  cfg_div = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] ce;
  logic              locked;
`ifdef CLK_EN_GEN_TOGGLE_EN
  logic [NUM_CH-1:0] clk_tgl;
`endif

  clk_en_gen #(
    .NUM_CH(NUM_CH),
    .ACC_W(ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_run(ch_run),
    .sync(sync),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_mul(cfg_mul),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .ce(ce),
`ifdef CLK_EN_GEN_TOGGLE_EN
    .clk_tgl(clk_tgl),
`endif
    .locked(locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: a channel that has run n edges since its last clear has
  // emitted floor(n*mul/div) pulses; it pulses when that count steps.
  longint m_mul [NUM_CH];
  longint m_div [NUM_CH];
  longint m_n   [NUM_CH];
  logic [NUM_CH-1:0] exp_ce;
  logic [NUM_CH-1:0] exp_tgl;
  logic exp_err;
  logic exp_locked;
  int   lock_left;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_mul[i] = 1;
      m_div[i] = 1;
      m_n[i]   = 0;
    end
    exp_ce     = '0;
    exp_tgl    = '0;
    exp_err    = 1'b0;
    exp_locked = 1'b0;
    lock_left  = LOCK_CYCLES;
  endfunction

  function automatic void model_edge();
    logic ok;
    logic [NUM_CH-1:0] old_ce;
    old_ce = exp_ce;
    ok = cfg_we && (int'(cfg_ch) < NUM_CH) &&
         (cfg_div != 0) && (cfg_mul <= cfg_div);
    exp_err    = cfg_we && !ok;
    exp_locked = (lock_left == 0);
    if (ok || sync) lock_left = LOCK_CYCLES;
    else if (lock_left > 0) lock_left--;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync || (ok && int'(cfg_ch) == i)) begin
        if (ok && int'(cfg_ch) == i) begin
          m_mul[i] = longint'(cfg_mul);
          m_div[i] = longint'(cfg_div);
        end
        m_n[i]     = 0;
        exp_ce[i]  = 1'b0;
        exp_tgl[i] = 1'b0;
      end else begin
        exp_tgl[i] = exp_tgl[i] ^ old_ce[i];
        if (ch_run[i]) begin
          m_n[i]++;
          exp_ce[i] = (m_n[i] * m_mul[i] / m_div[i]) !=
                      ((m_n[i] - 1) * m_mul[i] / m_div[i]);
        end else begin
          exp_ce[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int mul,
                           input int dv);
    cfg_we  = 1'b1;
    cfg_ch  = 3'(ch);
    cfg_mul = ACC_W'(mul);
    cfg_div = ACC_W'(dv);
    step();
    cfg_we  = 1'b0;
  endtask

  function automatic logic ref_pulse(input longint k,
                                     input longint mul,
                                     input longint dv);
    return (k * mul / dv) != ((k - 1) * mul / dv);
  endfunction

  task automatic test_reset();
    int lock_edge;
    lock_edge = -1;
    rst_n  = 1'b0;
    ch_run = '1;
    #13;
    n_checks++;
    if (ce !== '0) begin
      n_fail++;
      $display("FAIL reset_ce got %b want 0", ce);
    end
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_locked got %b want 0", locked);
    end
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b want 0", cfg_err);
    end
`ifdef CLK_EN_GEN_TOGGLE_EN
    n_checks++;
    if (clk_tgl !== '0) begin
      n_fail++;
      $display("FAIL reset_tgl got %b want 0", clk_tgl);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 70; k++) begin
      step();
      n_checks++;
      if (ce !== 5'b11111 || ce !== exp_ce) begin
        n_fail++;
        $display("FAIL reset_run_ce edge %0d got %b want %b",
                 k, ce, exp_ce);
      end
      n_checks++;
      if (locked !== exp_locked) begin
        n_fail++;
        $display("FAIL reset_lock edge %0d got %b want %b",
                 k, locked, exp_locked);
      end
      if (locked === 1'b1 && lock_edge < 0) lock_edge = k;
    end
    n_checks++;
    if (lock_edge != LOCK_CYCLES + 1) begin
      n_fail++;
      $display("FAIL lock_edge got %0d want %0d",
               lock_edge, LOCK_CYCLES + 1);
    end
  endtask

  task automatic test_ratio();
    int cnt, first, last;
    logic bad_gap;
    cnt = 0; first = -1; last = -1; bad_gap = 1'b0;
    ch_run = '1;
    cfg_write(1, 3, 7);
    for (int k = 1; k <= 70; k++) begin
      step();
      n_checks++;
      if (ce !== exp_ce || locked !== exp_locked) begin
        n_fail++;
        $display("FAIL ratio_cyc edge %0d got %b/%b want %b/%b",
                 k, ce, locked, exp_ce, exp_locked);
      end
`ifdef CLK_EN_GEN_TOGGLE_EN
      n_checks++;
      if (clk_tgl !== exp_tgl) begin
        n_fail++;
        $display("FAIL ratio_tgl edge %0d got %b want %b",
                 k, clk_tgl, exp_tgl);
      end
`endif
      if (ce[1] === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
        if (last >= 0 && (k - last < 2 || k - last > 3))
          bad_gap = 1'b1;
        last = k;
      end
    end
    n_checks++;
    if (cnt != 30) begin
      n_fail++;
      $display("FAIL ratio_count got %0d want 30", cnt);
    end
    n_checks++;
    if (first != 3) begin
      n_fail++;
      $display("FAIL ratio_first got %0d want 3", first);
    end
    n_checks++;
    if (bad_gap) begin
      n_fail++;
      $display("FAIL ratio_gap got gap outside 2..3 want 2..3");
    end
  endtask

  task automatic test_sync();
    ch_run = '1;
    cfg_write(3, 1, 28);
    cfg_write(4, 1, 4);
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      step();
      n_checks++;
      if (ce !== exp_ce || ce[3] !== (k % 28 == 0) ||
          ce[4] !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL sync_ce edge %0d got %b want %b",
                 k, ce, exp_ce);
      end
      if (k == 28) begin
        n_checks++;
        if (ce[4:3] !== 2'b11) begin
          n_fail++;
          $display("FAIL sync_align got %b want 11", ce[4:3]);
        end
      end
    end
  endtask

  task automatic test_reject();
    int bad_ch [3];
    int bad_mul [3];
    int bad_div [3];
    bad_ch  = '{2, 2, NUM_CH};
    bad_mul = '{5, 1, 1};
    bad_div = '{4, 0, 1};
    ch_run = '1;
    repeat (70) step();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rej_pre_lock got %b want 1", locked);
    end
    for (int w = 0; w < 3; w++) begin
      cfg_write(bad_ch[w], bad_mul[w], bad_div[w]);
      n_checks++;
      if (cfg_err !== 1'b1 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL rej_err w%0d got err=%b lk=%b want 1/1",
                 w, cfg_err, locked);
      end
      step();
      n_checks++;
      if (cfg_err !== 1'b0 || ce !== exp_ce) begin
        n_fail++;
        $display("FAIL rej_after w%0d got err=%b ce=%b want 0/%b",
                 w, cfg_err, ce, exp_ce);
      end
    end
    for (int k = 0; k < 28; k++) begin
      step();
      n_checks++;
      if (ce !== exp_ce || locked !== 1'b1 || cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rej_run k%0d got %b/%b want %b/1",
                 k, ce, locked, exp_ce);
      end
    end
  endtask

  task automatic test_pause();
    int cnt;
    logic want;
    cnt = 0;
    ch_run = '1;
    cfg_write(1, 3, 7);
    for (int k = 1; k <= 80; k++) begin
      ch_run[1] = !(k > 20 && k <= 30);
      step();
      if (k > 20 && k <= 30) want = 1'b0;
      else if (k <= 20) want = ref_pulse(k, 3, 7);
      else want = ref_pulse(k - 10, 3, 7);
      n_checks++;
      if (ce[1] !== want || ce !== exp_ce) begin
        n_fail++;
        $display("FAIL pause_ce edge %0d got %b want %b (%b)",
                 k, ce[1], want, exp_ce);
      end
      if (ce[1] === 1'b1) cnt++;
    end
    ch_run = '1;
    n_checks++;
    if (cnt != 30) begin
      n_fail++;
      $display("FAIL pause_count got %0d want 30", cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      ch_run  = NUM_CH'($urandom);
      sync    = ($urandom_range(0, 49) == 0);
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = 3'($urandom_range(0, 7));
      cfg_mul = ACC_W'($urandom_range(0, 12));
      cfg_div = ACC_W'($urandom_range(0, 12));
      step();
      n_checks++;
      if (ce !== exp_ce || locked !== exp_locked ||
          cfg_err !== exp_err) begin
        n_fail++;
        $display("FAIL rand k%0d got %b/%b/%b want %b/%b/%b",
                 k, ce, locked, cfg_err,
                 exp_ce, exp_locked, exp_err);
      end
`ifdef CLK_EN_GEN_TOGGLE_EN
      n_checks++;
      if (clk_tgl !== exp_tgl) begin
        n_fail++;
        $display("FAIL rand_tgl k%0d got %b want %b",
                 k, clk_tgl, exp_tgl);
      end
`endif
    end
    sync = 1'b0;
    cfg_we = 1'b0;
    ch_run = '1;
  endtask

  task automatic test_async_reset();
    ch_run = '1;
    cfg_write(0, 2, 2);
    repeat (70) step();
    n_checks++;
    if (ce[0] !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL ares_pre got ce0=%b lk=%b want 1/1",
               ce[0], locked);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ce !== '0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL ares_now got ce=%b lk=%b want 0/0",
               ce, locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (ce !== 5'b11111 || ce !== exp_ce || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL ares_run edge %0d got %b/%b want 11111/0",
                 k, ce, locked);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ratio();
    test_sync();
    test_reject();
    test_pause();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised, runtime-programmable clock-enable generator for the NES core.
- Next generation of the fixed-ratio PLL wrapper: one fast system clock drives NUM_CH fractional-rate single-cycle enable pulses (PPU, PPU/4, 6502, VGA, ...).
- Ratios are changeable at run time without resynthesis.
- Provides channel phase alignment and a lock indication.

Parameters:
- NUM_CH, 5, number of enable channels.
- ACC_W, 16, width of the per-channel mul/div and accumulator.
- LOCK_CYCLES, 64, cycles that `locked` stays low after reset, an accepted config write, or a sync.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- ch_run  input  NUM_CH  per-channel run level. 1 = accumulate; 0 = hold accumulator, ce forced 0.
- sync  input  1  one-cycle pulse; clears all accumulators (phase alignment).
- cfg_we  input  1  config write strobe.
- cfg_ch  input  $clog2(NUM_CH)  target channel index.
- cfg_mul  input  ACC_W  numerator.
- cfg_div  input  ACC_W  denominator.
- cfg_err  output  1  one-cycle pulse when a write is rejected.
- ce  output  NUM_CH  registered enable pulses, average rate f_clk*mul/div.
- locked  output  1  high when all channels are stable.

Behaviour:
- Reset (async assert, sync release):
  - every acc=0, mul=1, div=1.
  - ce=0, cfg_err=0, locked=0.
  - lock counter loaded with LOCK_CYCLES.
- Per channel, each rising edge with ch_run[i]=1 and no clear:
  - sum = acc + mul, computed in ACC_W+1 bits.
  - If sum >= div: ce[i] <= 1 and acc <= sum - div.
  - Else: ce[i] <= 0 and acc <= sum.
  - Invariant: acc < div always.
- ch_run[i]=0: acc held; ce[i] <= 0. Resuming continues from the held phase.
- Latency: the first pulse after clear/run occurs on edge ceil(div/mul). Example: mul=1, div=4 gives ce high after the 4th edge, then every 4th edge.
- mul == div: ce[i] high every cycle while running.
- Config write (cfg_we=1):
  - Accepted iff cfg_ch < NUM_CH, div != 0 and mul <= div.
  - On accept: mul/div of cfg_ch load on that edge, its acc <= 0 and ce[cfg_ch] <= 0. The new ratio is used from the next edge.
  - On reject: nothing changes, and cfg_err=1 on the following cycle only.
  - mul=0 is legal: the channel never pulses.
- sync=1: on that edge all acc <= 0 and all ce <= 0, whatever ch_run is.
- sync and cfg_we in the same cycle: both take effect. The written channel gets the new ratio with acc=0.
- Lock:
  - Counter reloads LOCK_CYCLES on reset, on an accepted write, and on sync.
  - It decrements to 0 and holds there.
  - locked=1 iff counter==0, registered.
  - A rejected write does not disturb lock.
- No other state. The outputs are pure registers, so ce is glitch-free.

Optional Feature:
- Macro: CLK_EN_GEN_TOGGLE_EN.
- When defined, adds output port clk_tgl [NUM_CH]: a per-channel register that inverts on every cycle its ce bit is 1.
  - This gives a square-ish divided clock at half the enable rate, for external pins and scope debug.
  - Reset value 0.
  - Cleared to 0 by sync and by an accepted write to its channel.
- When not defined, the port and its registers do not exist, and all other behaviour is identical.

Test Plan:
- After reset with no writes -> all ce high every cycle; locked rises exactly LOCK_CYCLES+1 edges after rst_n release.
- Write ch1 mul=3 div=7, run 70 cycles -> exactly 30 ce[1] pulses; inter-pulse gaps only 2 or 3 cycles; first pulse on edge 3.
- Write ch3 mul=1 div=28 and ch4 mul=1 div=4, then sync -> ce[3] every 28 cycles and ce[4] every 4 cycles; both pulse together on edge 28 after sync.
- Writes with mul=5 div=4, div=0 and cfg_ch=NUM_CH -> cfg_err pulses once per write; ratios unchanged; locked stays 1.
- ch_run[1] dropped for 10 cycles mid-phase -> ce[1]=0 throughout; pulse pattern resumes shifted by exactly 10 cycles; total pulse count unaffected.
- rst_n asserted mid-run, asynchronously between edges -> ce and locked go 0 immediately; after release, ratios are back to 1/1.
